// File: rtl/bus_reg_bank.sv
// -----------------------------------------------------------------------------
// bus_reg_bank
// A bank of NUM_REGS registers, WIDTH bits each, attached to a shared tristate
// bus. Each cycle one register may be loaded from the bus, one may drive the
// bus, and one may be incremented, decremented or cleared. A wrap flag records
// whether the last increment/decrement carried or borrowed. A sticky error flag
// records select conflicts and out-of-range selects.
//
// Ports
//   clk       system clock, all state changes on the rising edge
//   reset     synchronous active-low reset
//   bus       shared bidirectional bus (driven only while out_en selects a
//             valid register, otherwise high impedance)
//   load_en   capture bus into register load_sel
//   load_sel  load target
//   out_en    drive register out_sel onto bus
//   out_sel   drive source
//   op_en     apply op to register op_sel
//   op_sel    op target
//   op        00 none, 01 increment, 10 decrement, 11 clear
//   err_clr   clears the sticky error flag
//   reg_q     all register values, register i at [i*WIDTH +: WIDTH]
//   zero      zero[i] set while register i holds zero (combinational)
//   wrap      registered carry/borrow of the last increment/decrement
//   err       registered sticky error flag
// -----------------------------------------------------------------------------
module bus_reg_bank #(
    parameter int unsigned        WIDTH       = 32'd8,
    parameter int unsigned        NUM_REGS    = 32'd4,
    parameter int unsigned        SEL_W       = 32'd2,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                      clk,
    input  logic                      reset,
    inout  wire  [WIDTH-1:0]          bus,
    input  logic                      load_en,
    input  logic [SEL_W-1:0]          load_sel,
    input  logic                      out_en,
    input  logic [SEL_W-1:0]          out_sel,
    input  logic                      op_en,
    input  logic [SEL_W-1:0]          op_sel,
    input  logic [1:0]                op,
    input  logic                      err_clr,
    output logic [WIDTH*NUM_REGS-1:0] reg_q,
    output logic [NUM_REGS-1:0]       zero,
    output logic                      wrap,
    output logic                      err
);

    localparam logic [1:0]       OP_NONE = 2'b00;
    localparam logic [1:0]       OP_INC  = 2'b01;
    localparam logic [1:0]       OP_DEC  = 2'b10;
    localparam logic [1:0]       OP_CLR  = 2'b11;
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZER = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    // One extra bit so a NUM_REGS equal to 2**SEL_W still fits
    localparam logic [SEL_W:0]   NREGS_C = (SEL_W+1)'(NUM_REGS);

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic             wrap_q;
    logic             wrap_d;
    logic             err_q;
    logic             err_d;

    logic [WIDTH-1:0] out_val_s;
    logic [WIDTH-1:0] op_val_s;
    logic             drive_s;
    logic             load_ok_s;
    logic             op_ok_s;
    logic             conflict_s;
    logic             range_err_s;
    logic             step_s;

    function automatic logic sel_in_range(input logic [SEL_W-1:0] sel);
        return ({1'b0, sel} < NREGS_C);
    endfunction

    // Read muxes for the bus drive source and the op target; out-of-range
    // selects fall through to zero and are never used
    always_comb begin
        out_val_s = ALL_ZER;
        op_val_s  = ALL_ZER;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (out_sel == SEL_W'(i)) begin
                out_val_s = regs_q[i];
            end else begin
                out_val_s = out_val_s;
            end
            if (op_sel == SEL_W'(i)) begin
                op_val_s = regs_q[i];
            end else begin
                op_val_s = op_val_s;
            end
        end
    end

    assign drive_s = out_en && sel_in_range(out_sel);
    assign bus     = drive_s ? out_val_s : {WIDTH{1'bz}};

    // Next-state decode for registers, wrap and err
    always_comb begin
        regs_d      = regs_q;
        wrap_d      = wrap_q;
        err_d       = err_q;
        load_ok_s   = load_en && sel_in_range(load_sel);
        op_ok_s     = op_en && sel_in_range(op_sel) && (op != OP_NONE);
        // Load and a real op on the same register: clear beats load,
        // load beats increment/decrement
        conflict_s  = load_ok_s && op_ok_s && (load_sel == op_sel);
        range_err_s = (load_en && !sel_in_range(load_sel)) ||
                      (out_en  && !sel_in_range(out_sel))  ||
                      (op_en   && !sel_in_range(op_sel));
        step_s      = op_ok_s && !conflict_s && ((op == OP_INC) || (op == OP_DEC));

        if (step_s) begin
            if (op == OP_INC) begin
                wrap_d = (op_val_s == ALL_ONE);
            end else begin
                wrap_d = (op_val_s == ALL_ZER);
            end
        end else begin
            wrap_d = wrap_q;
        end

        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (op_ok_s && (op_sel == SEL_W'(i)) && (op == OP_CLR)) begin
                regs_d[i] = RESET_VALUE;
            end else if (load_ok_s && (load_sel == SEL_W'(i))) begin
                // On self-transfer bus carries this register's own value
                regs_d[i] = bus;
            end else if (step_s && (op_sel == SEL_W'(i))) begin
                case (op)
                    OP_INC:  regs_d[i] = op_val_s + ONE;
                    OP_DEC:  regs_d[i] = op_val_s - ONE;
                    default: regs_d[i] = regs_q[i];
                endcase
            end else begin
                regs_d[i] = regs_q[i];
            end
        end

        // A new error in the same cycle as err_clr still sets the flag
        if (range_err_s || conflict_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= RESET_VALUE;
            end
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    // Flatten register contents and derive per-register zero flags
    always_comb begin
        reg_q = {(WIDTH*NUM_REGS){1'b0}};
        zero  = {NUM_REGS{1'b0}};
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            reg_q[i*WIDTH +: WIDTH] = regs_q[i];
            zero[i]                 = (regs_q[i] == ALL_ZER);
        end
    end

    assign wrap = wrap_q;
    assign err  = err_q;

endmodule
